// File: rtl/bus_interconnect_if.sv
// Bus bundle between the CPU, the interconnect and its N slave channels.
// The slave modport is the fabric's view; master is the environment's view.
interface bus_interconnect_if #(
    parameter int N = 8
);
    logic            i_bus_request;
    logic            i_bus_rw;
    logic [31:0]     i_bus_address;
    logic [31:0]     i_bus_wdata;
    logic [31:0]     o_bus_rdata;
    logic            o_bus_ready;
    logic            o_bus_error;
    logic [N-1:0]    o_slave_request;
    logic            o_slave_rw;
    logic [N*32-1:0] o_slave_address;
    logic [31:0]     o_slave_wdata;
    logic [N*32-1:0] i_slave_rdata;
    logic [N-1:0]    i_slave_ready;

    modport slave (
        input  i_bus_request, i_bus_rw, i_bus_address, i_bus_wdata,
        input  i_slave_rdata, i_slave_ready,
        output o_bus_rdata, o_bus_ready, o_bus_error,
        output o_slave_request, o_slave_rw, o_slave_address,
        output o_slave_wdata
    );

    modport master (
        output i_bus_request, i_bus_rw, i_bus_address, i_bus_wdata,
        output i_slave_rdata, i_slave_ready,
        input  o_bus_rdata, o_bus_ready, o_bus_error,
        input  o_slave_request, o_slave_rw, o_slave_address,
        input  o_slave_wdata
    );
endinterface

// File: rtl/bus_interconnect.sv
// Registered single-master to N-slave fabric with region decode and timeout.
// Optional fault capture: define BUS_INTERCONNECT_FAULT_CAPTURE_EN.
module bus_interconnect #(
    parameter int              N           = 8,
    parameter logic [N*32-1:0] REGION_BASE = {N{32'h0}},
    parameter logic [N*32-1:0] REGION_SIZE = {N{32'h0}},
    parameter int              TIMEOUT     = 1024,
    parameter logic [31:0]     ERROR_RDATA = 32'h0000_0000
) (
    input  logic i_clock,
    input  logic i_reset,
`ifdef BUS_INTERCONNECT_FAULT_CAPTURE_EN
    input  logic        i_fault_clear,
    output logic        o_fault_valid,
    output logic [31:0] o_fault_address,
    output logic        o_fault_timeout,
`endif
    bus_interconnect_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERROR,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_rw;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_ready;
    logic            r_error;
    logic [N-1:0]    r_sreq;
    logic [N*32-1:0] r_saddr;
    logic [31:0]     r_count;

    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic [32:0]     w_addr;
    logic [32:0]     w_lo;
    logic [32:0]     w_hi;
    logic            w_sel_ready;
    logic            w_timeout;

    // 33-bit bounds so a region ending at 2^32 does not wrap; lowest index wins
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_addr = {1'b0, bus.i_bus_address};
        w_lo   = '0;
        w_hi   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_lo = {1'b0, REGION_BASE[32*i +: 32]};
            w_hi = w_lo + {1'b0, REGION_SIZE[32*i +: 32]};
            if (REGION_SIZE[32*i +: 32] != 32'h0 &&
                w_addr >= w_lo && w_addr < w_hi) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    assign w_sel_ready = bus.i_slave_ready[r_idx];
    assign w_timeout   = (TIMEOUT != 0) &&
                         (r_count == 32'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_sreq  <= '0;
            r_saddr <= '0;
            r_count <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_bus_request) begin
                        r_rw    <= bus.i_bus_rw;
                        r_wdata <= bus.i_bus_wdata;
                        r_idx   <= w_idx;
                        r_count <= '0;
                        for (int i = 0; i < N; i++) begin
                            r_saddr[32*i +: 32] <= bus.i_bus_address -
                                                   REGION_BASE[32*i +: 32];
                            r_sreq[i] <= w_hit && (w_idx == IW'(i));
                        end
                        r_state <= w_hit ? S_ACCESS : S_ERROR;
                    end
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        r_rdata <= bus.i_slave_rdata[32*r_idx +: 32];
                        r_sreq  <= '0;
                        r_ready <= 1'b1;
                        r_error <= 1'b0;
                        r_state <= S_RELEASE;
                    end else if (w_timeout) begin
                        r_rdata <= ERROR_RDATA;
                        r_sreq  <= '0;
                        r_ready <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_RELEASE;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                S_ERROR: begin
                    r_rdata <= ERROR_RDATA;
                    r_ready <= 1'b1;
                    r_error <= 1'b1;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!bus.i_bus_request) begin
                        r_ready <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_bus_rdata     = r_rdata;
    assign bus.o_bus_ready     = r_ready;
    assign bus.o_bus_error     = r_error;
    assign bus.o_slave_request = r_sreq;
    assign bus.o_slave_rw      = r_rw;
    assign bus.o_slave_address = r_saddr;
    assign bus.o_slave_wdata   = r_wdata;

`ifdef BUS_INTERCONNECT_FAULT_CAPTURE_EN
    logic        r_addr;
    logic [31:0] r_fault_addr_in;
    logic        r_fvalid;
    logic [31:0] r_faddr;
    logic        r_ftmo;
    logic        w_err_unmapped;
    logic        w_err_timeout;

    assign r_addr         = 1'b0;
    assign w_err_unmapped = (r_state == S_ERROR);
    assign w_err_timeout  = (r_state == S_ACCESS) &&
                            !w_sel_ready && w_timeout;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fault_addr_in <= '0;
        end else if (r_state == S_IDLE && bus.i_bus_request) begin
            r_fault_addr_in <= bus.i_bus_address;
        end
    end

    // first error sticks until cleared; a clear coinciding with an error takes it
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fvalid <= 1'b0;
            r_faddr  <= '0;
            r_ftmo   <= 1'b0;
        end else if ((w_err_unmapped || w_err_timeout) &&
                     (!r_fvalid || i_fault_clear)) begin
            r_fvalid <= 1'b1;
            r_faddr  <= r_fault_addr_in;
            r_ftmo   <= w_err_timeout;
        end else if (i_fault_clear) begin
            r_fvalid <= 1'b0;
        end
    end

    assign o_fault_valid   = r_fvalid;
    assign o_fault_address = r_faddr;
    assign o_fault_timeout = r_ftmo;
`endif
endmodule

// File: tb/tb_bus_interconnect.sv
// Randomized self-checking bench for bus_interconnect with a transaction model.
// Fault capture outputs are checked when BUS_INTERCONNECT_FAULT_CAPTURE_EN is set.
module tb_bus_interconnect;
    localparam int          N    = 6;
    localparam int          TMO  = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [N*32-1:0] BASE = {
        32'h0000_0000, 32'h3000_0000, 32'hFFFF_FF00,
        32'h5000_0010, 32'h0001_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] SIZE = {
        32'h0002_0010, 32'h0000_0000, 32'h0000_0100,
        32'h0000_0010, 32'h0001_0000, 32'h0001_0000};

    longint mb[N] = '{64'h0, 64'h10000, 64'h5000_0010,
                      64'hFFFF_FF00, 64'h3000_0000, 64'h0};
    longint ms[N] = '{64'h10000, 64'h10000, 64'h10,
                      64'h100, 64'h0, 64'h20010};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault_clear = 1'b0;
    logic        fv_o;
    logic [31:0] fa_o;
    logic        ft_o;

    bus_interconnect_if #(.N(N)) bif ();

`ifdef BUS_INTERCONNECT_FAULT_CAPTURE_EN
    bus_interconnect #(
        .N(N), .REGION_BASE(BASE), .REGION_SIZE(SIZE),
        .TIMEOUT(TMO), .ERROR_RDATA(ERRD)
    ) u_dut (
        .i_clock(clk), .i_reset(rst),
        .i_fault_clear(fault_clear), .o_fault_valid(fv_o),
        .o_fault_address(fa_o), .o_fault_timeout(ft_o),
        .bus(bif)
    );
`else
    bus_interconnect #(
        .N(N), .REGION_BASE(BASE), .REGION_SIZE(SIZE),
        .TIMEOUT(TMO), .ERROR_RDATA(ERRD)
    ) u_dut (
        .i_clock(clk), .i_reset(rst), .bus(bif)
    );
    assign fv_o = 1'b0;
    assign fa_o = '0;
    assign ft_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int obs_lat = 0;
    int sreq_cnt = 0;
    logic prev_rdy = 1'b0;

    bit          chk_en = 0;
    bit          exp_rst = 1;
    logic        exp_ready = 0;
    logic        exp_err = 0;
    logic [31:0] exp_rdata = 0;
    logic [N-1:0] exp_sreq = '0;
    int          exp_idx = 0;
    logic [31:0] exp_addr = 0;
    logic        exp_rw = 0;
    logic [31:0] exp_wd = 0;
    logic        m_fv = 0;
    logic [31:0] m_fa = 0;
    logic        m_ft = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    function automatic int decode(input logic [31:0] a);
        longint av;
        av = a;
        for (int i = 0; i < N; i++)
            if (ms[i] != 0 && av >= mb[i] && av < mb[i] + ms[i])
                return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bif.o_bus_ready === 1'b1 && prev_rdy !== 1'b1)
            obs_lat = cyc - t0;
        prev_rdy = bif.o_bus_ready;
        if (|bif.o_slave_request) sreq_cnt++;
    end

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bif.o_bus_ready), 32'(exp_ready));
            chk("error", 32'(bif.o_bus_error), 32'(exp_err));
            if (exp_ready) chk("rdata", bif.o_bus_rdata, exp_rdata);
            chk("sreq", 32'(bif.o_slave_request), 32'(exp_sreq));
            if (exp_sreq != '0) begin
                chk("srw", 32'(bif.o_slave_rw), 32'(exp_rw));
                chk("swdata", bif.o_slave_wdata, exp_wd);
                chk("saddr", bif.o_slave_address[32*exp_idx +: 32],
                    exp_addr);
            end
            if (exp_rst) begin
                chk("rst_rdata", bif.o_bus_rdata, 32'h0);
                chk("rst_rw", 32'(bif.o_slave_rw), 32'h0);
                chk("rst_wdata", bif.o_slave_wdata, 32'h0);
                for (int i = 0; i < N; i++)
                    chk("rst_saddr", bif.o_slave_address[32*i +: 32], 32'h0);
            end
`ifdef BUS_INTERCONNECT_FAULT_CAPTURE_EN
            chk("fvalid", 32'(fv_o), 32'(m_fv));
            if (m_fv) begin
                chk("faddr", fa_o, m_fa);
                chk("ftmo", 32'(ft_o), 32'(m_ft));
            end
`endif
        end
    end

    task automatic noise(input int keep);
        for (int i = 0; i < N; i++) begin
            if (i != keep) begin
                bif.i_slave_ready[i] = 1'($urandom_range(1));
                bif.i_slave_rdata[32*i +: 32] = $urandom;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access; slave answers in cycle k (cycle 1 follows request edge)
    task automatic do_access(input logic [31:0] a, input logic rw,
                             input logic [31:0] wd, input int k,
                             input logic [31:0] rd, input int hold,
                             input bit drop);
        int idx;
        int mc;
        bit tmo;
        bit clr;
        bit err;
        logic [31:0] res;
        idx = decode(a);
        bif.i_bus_request = 1'b1;
        bif.i_bus_address = a;
        bif.i_bus_rw = rw;
        bif.i_bus_wdata = wd;
        exp_rst = 0;
        sreq_cnt = 0;
        noise(-1);
        tick();
        t0 = cyc - 1;
        if (drop) begin
            bif.i_bus_request = 1'b0;
            bif.i_bus_address = $urandom;
            bif.i_bus_wdata = $urandom;
        end
        clr = ($urandom_range(3) == 0);
        if (idx >= 0) begin
            mc = (k < TMO) ? k : TMO;
            tmo = (k > TMO);
            exp_sreq = '0;
            exp_sreq[idx] = 1'b1;
            exp_idx = idx;
            exp_addr = 32'(longint'(a) - mb[idx]);
            exp_rw = rw;
            exp_wd = wd;
            for (int c = 1; c <= mc; c++) begin
                noise(idx);
                bif.i_slave_ready[idx] = (c >= k);
                bif.i_slave_rdata[32*idx +: 32] = (c >= k) ? rd : $urandom;
                fault_clear = (c == mc) ? clr : 1'b0;
                tick();
            end
            exp_sreq = '0;
            res = tmo ? ERRD : rd;
        end else begin
            tmo = 0;
            fault_clear = clr;
            tick();
            res = ERRD;
        end
        err = (idx < 0) || tmo;
        if (err && (!m_fv || clr)) begin
            m_fv = 1;
            m_fa = a;
            m_ft = tmo;
        end else if (clr) begin
            m_fv = 0;
        end
        fault_clear = 1'b0;
        exp_ready = 1;
        exp_err = err;
        exp_rdata = res;
        if (!drop) begin
            for (int h = 0; h < hold; h++) begin
                noise(-1);
                tick();
            end
        end
        bif.i_bus_request = 1'b0;
        noise(-1);
        tick();
        exp_ready = 0;
        exp_err = 0;
    endtask

    initial begin
        logic [31:0] a;
        int pick;
        int k;
        bif.i_bus_request = 1'b0;
        bif.i_bus_rw = 1'b0;
        bif.i_bus_address = '0;
        bif.i_bus_wdata = '0;
        bif.i_slave_ready = '0;
        bif.i_slave_rdata = '0;
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        tick();

        chk("dec_ch1", 32'(decode(32'h0001_0024)), 32'd1);
        chk("dec_unmapped", 32'(decode(32'h3000_0000)), 32'hFFFF_FFFF);
        chk("dec_overlap", 32'(decode(32'h0000_0100)), 32'd0);
        chk("dec_top", 32'(decode(32'hFFFF_FFFF)), 32'd3);
        chk("dec_ch5", 32'(decode(32'h0002_0008)), 32'd5);
        chk("dec_end_excl", 32'(decode(32'h5000_0020)), 32'hFFFF_FFFF);

        do_access(32'h0001_0024, 1'b0, 32'h0, 3, 32'hCAFE_BABE, 2, 0);
        chk("lat_read", 32'(obs_lat), 32'd4);
        chk("sreq_cycles_read", 32'(sreq_cnt), 32'd3);

        do_access(32'h5000_0014, 1'b1, 32'h1234_5678, 1, 32'h0, 0, 0);
        chk("lat_write", 32'(obs_lat), 32'd2);

        do_access(32'h3000_0000, 1'b0, 32'h0, 1, 32'h0, 1, 0);
        chk("lat_unmapped", 32'(obs_lat), 32'd2);
        chk("sreq_cycles_unmapped", 32'(sreq_cnt), 32'd0);

        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        m_fv = 0;
        do_access(32'h0000_0008, 1'b0, 32'h0, 100, 32'h0, 1, 0);
        chk("sreq_cycles_timeout", 32'(sreq_cnt), 32'd16);
        chk("lat_timeout", 32'(obs_lat), 32'd17);
`ifdef BUS_INTERCONNECT_FAULT_CAPTURE_EN
        chk("flt_valid_lit", 32'(fv_o), 32'd1);
        chk("flt_tmo_lit", 32'(ft_o), 32'd1);
        chk("flt_addr_lit", fa_o, 32'h0000_0008);
`endif

        do_access(32'h0000_0010, 1'b0, 32'h0, 16, 32'h0BAD_F00D, 0, 0);
        chk("lat_ready_at_timeout", 32'(obs_lat), 32'd17);
        do_access(32'h0000_0100, 1'b1, 32'hA5A5_5A5A, 2, 32'h1, 0, 0);
        do_access(32'hFFFF_FFFC, 1'b0, 32'h0, 2, 32'h7777_1234, 0, 0);
        do_access(32'h0001_0040, 1'b0, 32'h0, 4, 32'h4444_0000, 0, 1);

        // Reset in the middle of an access
        bif.i_bus_request = 1'b1;
        bif.i_bus_address = 32'h0001_0010;
        bif.i_bus_rw = 1'b0;
        exp_rst = 0;
        tick();
        exp_sreq = '0;
        exp_sreq[1] = 1'b1;
        exp_idx = 1;
        exp_addr = 32'h10;
        exp_rw = 1'b0;
        exp_wd = bif.i_bus_wdata;
        noise(1);
        bif.i_slave_ready[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_sreq = '0;
        exp_rst = 1;
        m_fv = 0;
        rst = 1'b0;
        bif.i_bus_request = 1'b0;
        tick();
        do_access(32'h0001_0020, 1'b0, 32'h0, 2, 32'h5555_AAAA, 0, 0);
        chk("lat_after_reset", 32'(obs_lat), 32'd3);

        for (int t = 0; t < 150; t++) begin
            pick = $urandom_range(7);
            case (pick)
                0: a = $urandom_range(32'hFFFF);
                1: a = 32'h0001_0000 + $urandom_range(32'hFFFF);
                2: a = 32'h5000_0010 + $urandom_range(15);
                3: a = 32'hFFFF_FF00 + $urandom_range(255);
                4: a = 32'h0002_0000 + $urandom_range(31);
                5: a = $urandom;
                6: begin
                    case ($urandom_range(3))
                        0: a = 32'h0001_FFFF;
                        1: a = 32'h5000_0020;
                        2: a = 32'h5000_000F;
                        default: a = 32'hFFFF_FEFF;
                    endcase
                end
                default: a = 32'h3000_0000 + $urandom_range(255);
            endcase
            k = ($urandom_range(7) == 0) ? $urandom_range(15, 18)
                                         : $urandom_range(1, 6);
            do_access(a, 1'($urandom_range(1)), $urandom, k, $urandom,
                      $urandom_range(3), ($urandom_range(7) == 0));
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
